opl3_host_wr_arbiter: RTL and testbench

Shares the OPL3 host bus between two register-write requesters, e.g. the CPU I/O port and an on-chip OPL music replay engine. Each accepted request is one complete register write: bank, register address and data. The block turns it into the two-phase OPL host cycle: an address strobe at port 0 or 2, then a data strobe at port 1 or 3. It enforces programmable strobe widths and recovery gaps so the downstream edge detectors and the timer-trick detector see clean, separated strobes.

---
 rtl/opl3_host_wr_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_opl3_host_wr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/opl3_host_wr_arbiter.sv
// opl3_host_wr_arbiter
// Shares the OPL3 host write bus between two register-write requesters.
// Each accepted request becomes an address strobe (port 0/2) followed by a
// data strobe (port 1/3), each followed by a recovery gap with cs_n/wr_n high.
// Optional build macro OPL3_ARB_ADDR_CACHE_EN: remember the last {bank, reg}
// that completed an address strobe and skip the address phase on a repeat.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | bus idle, arbitrating, may accept a request this cycle
// ST_A_STRB | cs_n/wr_n low, address = {bank,0}, dout = register address
// ST_A_GAP  | cs_n/wr_n high after the address strobe
// ST_D_STRB | cs_n/wr_n low, address = {bank,1}, dout = register data
// ST_D_GAP  | cs_n/wr_n high after the data strobe, then back to idle
module opl3_host_wr_arbiter #(
    parameter int STROBE_CYCLES       = 4,
    parameter int GAP_CYCLES          = 8,
    parameter int REG_FILE_DATA_WIDTH = 8
) (
    input  logic                           clk_host,
    input  logic                           ic_n,
    input  logic                           req0_valid,
    output logic                           req0_ready,
    input  logic                           req0_bank,
    input  logic [REG_FILE_DATA_WIDTH-1:0] req0_address,
    input  logic [REG_FILE_DATA_WIDTH-1:0] req0_data,
    input  logic                           req1_valid,
    output logic                           req1_ready,
    input  logic                           req1_bank,
    input  logic [REG_FILE_DATA_WIDTH-1:0] req1_address,
    input  logic [REG_FILE_DATA_WIDTH-1:0] req1_data,
    output logic                           cs_n,
    output logic                           wr_n,
    output logic                           rd_n,
    output logic [1:0]                     address,
    output logic [REG_FILE_DATA_WIDTH-1:0] dout,
    output logic                           busy,
    output logic                           grant_id
);

    localparam int MAX_LEN = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    generate
        if (STROBE_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
            $fatal(1, "opl3_host_wr_arbiter: STROBE_CYCLES and GAP_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_A_STRB = 3'd1,
        ST_A_GAP  = 3'd2,
        ST_D_STRB = 3'd3,
        ST_D_GAP  = 3'd4
    } state_t;

    state_t                         r_state;
    logic [CW-1:0]                  r_cnt;
    logic                           r_cs_n;
    logic                           r_wr_n;
    logic [1:0]                     r_address;
    logic [REG_FILE_DATA_WIDTH-1:0] r_dout;
    logic                           r_grant_id;
    logic                           r_last_grant;
    logic                           r_bank;
    logic [REG_FILE_DATA_WIDTH-1:0] r_data;

    logic                           w_idle;
    logic                           w_grant;
    logic                           w_accept;
    logic                           w_hit;
    logic                           w_sel_bank;
    logic [REG_FILE_DATA_WIDTH-1:0] w_sel_addr;
    logic [REG_FILE_DATA_WIDTH-1:0] w_sel_data;

`ifdef OPL3_ARB_ADDR_CACHE_EN
    logic                           r_addr;
    logic [REG_FILE_DATA_WIDTH-1:0] r_reg_addr;
    logic                           r_cache_valid;
    logic                           r_cache_bank;
    logic [REG_FILE_DATA_WIDTH-1:0] r_cache_addr;
`endif

    // Round-robin arbitration and request mux, only meaningful in idle.
    always_comb begin
        w_idle  = (r_state == ST_IDLE);
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
        w_accept   = w_idle && (req0_valid || req1_valid);
        req0_ready = w_idle && req0_valid && !w_grant;
        req1_ready = w_idle && req1_valid && w_grant;
        w_sel_bank = w_grant ? req1_bank    : req0_bank;
        w_sel_addr = w_grant ? req1_address : req0_address;
        w_sel_data = w_grant ? req1_data    : req0_data;
`ifdef OPL3_ARB_ADDR_CACHE_EN
        w_hit = r_cache_valid && (r_cache_bank == w_sel_bank) && (r_cache_addr == w_sel_addr);
`else
        w_hit = 1'b0;
`endif
    end

    // Strobe sequencer: every state is timed by the down-counter, advancing at 1.
    always_ff @(posedge clk_host or negedge ic_n) begin
        if (!ic_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cs_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_address    <= 2'b00;
            r_dout       <= '0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_bank       <= 1'b0;
            r_data       <= '0;
`ifdef OPL3_ARB_ADDR_CACHE_EN
            r_addr        <= 1'b0;
            r_reg_addr    <= '0;
            r_cache_valid <= 1'b0;
            r_cache_bank  <= 1'b0;
            r_cache_addr  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_bank       <= w_sel_bank;
                        r_data       <= w_sel_data;
                        r_last_grant <= w_grant;
                        r_grant_id   <= w_grant;
                        r_cs_n       <= 1'b0;
                        r_wr_n       <= 1'b0;
                        r_cnt        <= STROBE_LD;
`ifdef OPL3_ARB_ADDR_CACHE_EN
                        r_addr     <= 1'b1;
                        r_reg_addr <= w_sel_addr;
`endif
                        if (w_hit) begin
                            r_state   <= ST_D_STRB;
                            r_address <= {w_sel_bank, 1'b1};
                            r_dout    <= w_sel_data;
                        end else begin
                            r_state   <= ST_A_STRB;
                            r_address <= {w_sel_bank, 1'b0};
                            r_dout    <= w_sel_addr;
                        end
                    end
                end
                ST_A_STRB: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_A_GAP;
                        r_cnt   <= GAP_LD;
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
`ifdef OPL3_ARB_ADDR_CACHE_EN
                        // The chip now holds this register address latched.
                        r_cache_valid <= r_addr;
                        r_cache_bank  <= r_bank;
                        r_cache_addr  <= r_reg_addr;
`endif
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_A_GAP: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state   <= ST_D_STRB;
                        r_cnt     <= STROBE_LD;
                        r_cs_n    <= 1'b0;
                        r_wr_n    <= 1'b0;
                        r_address <= {r_bank, 1'b1};
                        r_dout    <= r_data;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_D_STRB: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_D_GAP;
                        r_cnt   <= GAP_LD;
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_D_GAP: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_cs_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                end
            endcase
        end
    end

    assign cs_n     = r_cs_n;
    assign wr_n     = r_wr_n;
    assign rd_n     = 1'b1;
    assign address  = r_address;
    assign dout     = r_dout;
    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_opl3_host_wr_arbiter.sv
// Directed bench for opl3_host_wr_arbiter: a vector table of single writes
// plus hand sequences for arbitration fairness, mid-transfer reset and a
// minimum-timing instance. Adapts expectations to OPL3_ARB_ADDR_CACHE_EN.
module tb_opl3_host_wr_arbiter;

    localparam int S = 4;
    localparam int G = 8;
`ifdef OPL3_ARB_ADDR_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic       clk_host = 1'b0;
    logic       ic_n;
    logic       req0_valid, req0_bank, req1_valid, req1_bank;
    logic [7:0] req0_address, req0_data, req1_address, req1_data;
    logic       req0_ready, req1_ready;
    logic       cs_n, wr_n, rd_n, busy, grant_id;
    logic [1:0] address;
    logic [7:0] dout;

    logic       f_req0_valid, f_req0_bank, f_req1_valid, f_req1_bank;
    logic [7:0] f_req0_address, f_req0_data, f_req1_address, f_req1_data;
    logic       f_req0_ready, f_req1_ready;
    logic       f_cs_n, f_wr_n, f_rd_n, f_busy, f_grant_id;
    logic [1:0] f_address;
    logic [7:0] f_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_host = ~clk_host;

    opl3_host_wr_arbiter #(.STROBE_CYCLES(S), .GAP_CYCLES(G), .REG_FILE_DATA_WIDTH(8)) u_dut (
        .clk_host(clk_host), .ic_n(ic_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bank(req0_bank),
        .req0_address(req0_address), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bank(req1_bank),
        .req1_address(req1_address), .req1_data(req1_data),
        .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .address(address), .dout(dout),
        .busy(busy), .grant_id(grant_id)
    );

    opl3_host_wr_arbiter #(.STROBE_CYCLES(1), .GAP_CYCLES(1), .REG_FILE_DATA_WIDTH(8)) u_dut_fast (
        .clk_host(clk_host), .ic_n(ic_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_bank(f_req0_bank),
        .req0_address(f_req0_address), .req0_data(f_req0_data),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_bank(f_req1_bank),
        .req1_address(f_req1_address), .req1_data(f_req1_data),
        .cs_n(f_cs_n), .wr_n(f_wr_n), .rd_n(f_rd_n), .address(f_address), .dout(f_dout),
        .busy(f_busy), .grant_id(f_grant_id)
    );

    typedef struct {
        logic       req;
        logic       bank;
        logic [7:0] addr;
        logic [7:0] data;
        logic       hit_if_cached;
    } vec_t;

    vec_t vecs[7];

    task automatic check_vec(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // {cs_n, wr_n, rd_n, busy, grant_id, address, dout}
    function automatic logic [14:0] bus_vec();
        return {cs_n, wr_n, rd_n, busy, grant_id, address, dout};
    endfunction

    function automatic logic [14:0] f_bus_vec();
        return {f_cs_n, f_wr_n, f_rd_n, f_busy, f_grant_id, f_address, f_dout};
    endfunction

    function automatic logic [14:0] exp_vec(input logic strb_n, input logic bsy, input logic gid,
                                            input logic [1:0] a, input logic [7:0] d);
        return {strb_n, strb_n, 1'b1, bsy, gid, a, d};
    endfunction

    task automatic set_req(input logic req, input logic v, input logic bank,
                           input logic [7:0] addr, input logic [7:0] data);
        if (req) begin
            req1_valid = v; req1_bank = bank; req1_address = addr; req1_data = data;
        end else begin
            req0_valid = v; req0_bank = bank; req0_address = addr; req0_data = data;
        end
    endtask

    task automatic do_write(input vec_t v, input string tag);
        bit   got;
        logic hit;
        int   len;
        int   p;
        logic [14:0] e;
        hit = CACHE_ON && v.hit_if_cached;
        @(posedge clk_host); #1;
        set_req(v.req, 1'b1, v.bank, v.addr, v.data);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_host);
            if ((v.req ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check_int({tag, " accept"}, int'(got), 1);
        if (!got) begin
            set_req(v.req, 1'b0, 1'b0, 8'h00, 8'h00);
            return;
        end
        check_int({tag, " other_ready"}, int'(v.req ? req0_ready : req1_ready), 0);
        @(posedge clk_host); #1;
        set_req(v.req, 1'b0, ~v.bank, ~v.addr, ~v.data);
        len = hit ? (S + G) : 2 * (S + G);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk_host);
            p = hit ? (k + S + G) : k;
            if (p <= S)                e = exp_vec(1'b0, 1'b1, v.req, {v.bank, 1'b0}, v.addr);
            else if (p <= S + G)       e = exp_vec(1'b1, 1'b1, v.req, {v.bank, 1'b0}, v.addr);
            else if (p <= 2 * S + G)   e = exp_vec(1'b0, 1'b1, v.req, {v.bank, 1'b1}, v.data);
            else                       e = exp_vec(1'b1, 1'b1, v.req, {v.bank, 1'b1}, v.data);
            check_vec($sformatf("%s cyc%0d", tag, k), bus_vec(), e);
        end
        @(negedge clk_host);
        check_vec({tag, " idle"}, bus_vec(), exp_vec(1'b1, 1'b0, v.req, {v.bank, 1'b1}, v.data));
    endtask

    initial begin
        int   idx, last_cyc, exp_gid;
        bit   got;
        vec_t rv;

        vecs[0] = '{1'b0, 1'b0, 8'h04, 8'h21, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'h05, 8'h01, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h7F, 8'h80, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 8'h02, 8'hFF, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h02, 8'hFE, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 8'h02, 8'h55, 1'b0};

        ic_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        f_req0_valid = 1'b0; f_req0_bank = 1'b0; f_req0_address = 8'h00; f_req0_data = 8'h00;
        f_req1_valid = 1'b0; f_req1_bank = 1'b0; f_req1_address = 8'h00; f_req1_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_host);
        check_vec("reset bus", bus_vec(), exp_vec(1'b1, 1'b0, 1'b0, 2'b00, 8'h00));
        check_vec("reset fast bus", f_bus_vec(), exp_vec(1'b1, 1'b0, 1'b0, 2'b00, 8'h00));
        ic_n = 1'b1;

        // Fairness: both requesters held valid for four transfers
        @(posedge clk_host); #1;
        set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'hA0);
        set_req(1'b1, 1'b1, 1'b1, 8'h11, 8'hB1);
        idx = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk_host);
            if (idx > 0 && cyc == last_cyc + 1) begin
                exp_gid = (idx - 1) % 2;
                check_int($sformatf("fair grant_id %0d", idx - 1), int'(grant_id), exp_gid);
            end
            if (req0_ready || req1_ready) begin
                check_int("fair one_ready", int'(req0_ready) + int'(req1_ready), 1);
                check_int($sformatf("fair order %0d", idx), int'(req1_ready), idx % 2);
                if (idx > 0) check_int($sformatf("fair spacing %0d", idx), cyc - last_cyc, 2 * (S + G) + 1);
                last_cyc = cyc;
                idx++;
                if (idx == 4) break;
            end
        end
        check_int("fair accepts", idx, 4);
        @(posedge clk_host); #1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk_host);
        check_int("fair last grant_id", int'(grant_id), 1);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_host);
            if (!busy) begin got = 1'b1; break; end
        end
        check_int("fair drain", int'(got), 1);

        // Table of single writes
        foreach (vecs[i]) do_write(vecs[i], $sformatf("vec%0d", i));

        // Reset during the data strobe
        @(posedge clk_host); #1;
        set_req(1'b0, 1'b1, 1'b0, 8'h3C, 8'h5A);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_host);
            if (req0_ready) begin got = 1'b1; break; end
        end
        check_int("rst accept", int'(got), 1);
        @(posedge clk_host); #1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (S + G + 1) @(negedge clk_host);
        check_vec("rst pre", bus_vec(), exp_vec(1'b0, 1'b1, 1'b0, 2'b01, 8'h5A));
        #1 ic_n = 1'b0;
        #1 check_vec("rst async", bus_vec(), exp_vec(1'b1, 1'b0, 1'b0, 2'b00, 8'h00));
        @(negedge clk_host);
        ic_n = 1'b1;
        rv = '{1'b0, 1'b0, 8'h3C, 8'h77, 1'b0};
        do_write(rv, "post_rst");
        rv = '{1'b0, 1'b0, 8'h3C, 8'h78, 1'b1};
        do_write(rv, "post_rst_rep");

        // Minimum timing instance: 1-cycle strobes and gaps, back to back
        @(posedge clk_host); #1;
        f_req0_valid = 1'b1; f_req0_bank = 1'b0; f_req0_address = 8'h33; f_req0_data = 8'h44;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_host);
            if (f_req0_ready) begin got = 1'b1; break; end
        end
        check_int("fast accept", int'(got), 1);
        @(posedge clk_host); #1;
        f_req0_address = 8'h35;
        @(negedge clk_host);
        check_vec("fast a_strb", f_bus_vec(), exp_vec(1'b0, 1'b1, 1'b0, 2'b00, 8'h33));
        @(negedge clk_host);
        check_vec("fast a_gap", f_bus_vec(), exp_vec(1'b1, 1'b1, 1'b0, 2'b00, 8'h33));
        @(negedge clk_host);
        check_vec("fast d_strb", f_bus_vec(), exp_vec(1'b0, 1'b1, 1'b0, 2'b01, 8'h44));
        @(negedge clk_host);
        check_vec("fast d_gap", f_bus_vec(), exp_vec(1'b1, 1'b1, 1'b0, 2'b01, 8'h44));
        @(negedge clk_host);
        check_int("fast reaccept", int'(f_req0_ready), 1);
        check_int("fast idle", int'(f_busy), 0);
        @(posedge clk_host); #1;
        f_req0_valid = 1'b0;
        @(negedge clk_host);
        check_vec("fast 2nd a_strb", f_bus_vec(), exp_vec(1'b0, 1'b1, 1'b0, 2'b00, 8'h35));
        repeat (4) @(negedge clk_host);
        check_int("fast 2nd done", int'(f_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
